// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encoding, field widths and limits for the clock time controller
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 4;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 11;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - wrap-around counter 0..MAX with combinational carry-out
module mod_counter #(
    parameter int MAX   = 59,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Carry reflects the increment request only; callers qualify it by mode.
    assign carry = increment && (value == MAX_V);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (enable && increment) begin
            value <= (value == MAX_V) ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_time_controller.sv
// rtl/clock_time_controller.sv - hh:mm:ss AM/PM timekeeping with button-driven time-set modes
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int BLINK_TICKS = 1
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              pm,
    output logic [1:0]        mode,
    output logic              blink
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_d;

    logic in_run, in_set_hour, in_set_min, inc_ok;
    logic sec_carry, min_carry, hour_carry;
    logic min_inc, hour_inc, sec_clear;

    assign in_run      = (state_q == MODE_RUN);
    assign in_set_hour = (state_q == MODE_SET_HOUR);
    assign in_set_min  = (state_q == MODE_SET_MIN);

    // A mode press in the same cycle swallows the increment.
    assign inc_ok = btn_inc && !btn_mode;

    assign min_inc   = (in_run && sec_carry) || (in_set_min && inc_ok);
    assign hour_inc  = (in_run && sec_carry && min_carry) || (in_set_hour && inc_ok);
    assign sec_clear = in_set_min && btn_mode;

    mod_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk       (clockIn),
        .reset     (reset),
        .enable    (in_run),
        .increment (tick_1hz),
        .clear     (sec_clear),
        .value     (sec),
        .carry     (sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
        .clk       (clockIn),
        .reset     (reset),
        .enable    (1'b1),
        .increment (min_inc),
        .clear     (1'b0),
        .value     (min),
        .carry     (min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
        .clk       (clockIn),
        .reset     (reset),
        .enable    (1'b1),
        .increment (hour_inc),
        .clear     (1'b0),
        .value     (hour),
        .carry     (hour_carry)
    );

    // Any 11->0 hour wrap, from the run chain or from SET_HOUR, flips AM/PM.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            pm <= 1'b0;
        end else if (hour_carry) begin
            pm <= ~pm;
        end
    end

    always_ff @(posedge clockIn) begin
        if (reset) begin
            state_q     <= MODE_RUN;
            blink       <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            blink       <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blink_d     = blink;
        blink_cnt_d = blink_cnt_q;

        case (state_q)
            MODE_RUN:      if (btn_mode) state_d = MODE_SET_HOUR;
            MODE_SET_HOUR: if (btn_mode) state_d = MODE_SET_MIN;
            MODE_SET_MIN:  if (btn_mode) state_d = MODE_RUN;
            default:       state_d = MODE_RUN;
        endcase

        if (state_d != state_q) begin
            blink_d     = (state_d != MODE_RUN);
            blink_cnt_d = '0;
        end else if (!in_run && tick_1hz) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d     = ~blink;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// tb/tb_clock_time_controller.sv - scoreboard bench for clock_time_controller
module tb_clock_time_controller;

    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [5:0] sec, min;
    logic [3:0] hour;
    logic       pm, blink;
    logic [1:0] mode;

    always #5 clk = ~clk;

    clock_time_controller #(.BLINK_TICKS(BT)) dut (
        .clockIn  (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .pm       (pm),
        .mode     (mode),
        .blink    (blink)
    );

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [3:0] hour;
        logic       pm;
        logic [1:0] mode;
        logic       blink;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_sec = 0, m_min = 0, m_hour = 0, m_mode = 0, m_bcnt = 0;
    logic m_pm = 1'b0, m_blink = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.sec   = 6'(m_sec);
        o.min   = 6'(m_min);
        o.hour  = 4'(m_hour);
        o.pm    = m_pm;
        o.mode  = 2'(m_mode);
        o.blink = m_blink;
        return o;
    endfunction

    task automatic blink_tick();
        m_bcnt++;
        if (m_bcnt == BT) begin
            m_blink = ~m_blink;
            m_bcnt  = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic t, input logic bm, input logic bi);
        logic inc;
        inc = bi && !bm;
        if (r) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_bcnt = 0;
            m_pm = 1'b0; m_blink = 1'b0;
            return;
        end
        case (m_mode)
            0: begin
                if (t) begin
                    if (m_sec == 59) begin
                        m_sec = 0;
                        if (m_min == 59) begin
                            m_min = 0;
                            if (m_hour == 11) begin
                                m_hour = 0;
                                m_pm   = ~m_pm;
                            end else m_hour++;
                        end else m_min++;
                    end else m_sec++;
                end
                if (bm) begin m_mode = 1; m_blink = 1'b1; m_bcnt = 0; end
            end
            1: begin
                if (inc) begin
                    if (m_hour == 11) begin m_hour = 0; m_pm = ~m_pm; end
                    else m_hour++;
                end
                if (bm) begin m_mode = 2; m_blink = 1'b1; m_bcnt = 0; end
                else if (t) blink_tick();
            end
            default: begin
                if (inc) m_min = (m_min + 1) % 60;
                if (bm) begin m_mode = 0; m_sec = 0; m_blink = 1'b0; m_bcnt = 0; end
                else if (t) blink_tick();
            end
        endcase
    endtask

    task automatic cycle(input logic r, input logic t, input logic bm, input logic bi, input string tag);
        exp_t e;
        @(negedge clk);
        reset = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        model_step(r, t, bm, bi);
        e.v   = model_obs();
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Idle cycle whose expected outputs are written out by hand.
    task automatic hand(input int s, input int m, input int h, input int p,
                        input int md, input int b, input string tag);
        exp_t e;
        @(negedge clk);
        reset = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        e.v.sec   = 6'(s);
        e.v.min   = 6'(m);
        e.v.hour  = 4'(h);
        e.v.pm    = 1'(p);
        e.v.mode  = 2'(md);
        e.v.blink = 1'(b);
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {sec, min, hour, pm, mode, blink};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got sec=%0d min=%0d hour=%0d pm=%0d mode=%0d blink=%0d, expected sec=%0d min=%0d hour=%0d pm=%0d mode=%0d blink=%0d",
                             e.tag, act.sec, act.min, act.hour, act.pm, act.mode, act.blink,
                             e.v.sec, e.v.min, e.v.hour, e.v.pm, e.v.mode, e.v.blink);
                end
            end
        end
    end

    initial begin
        logic exp_b [4];
        exp_b = '{1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), "reset_hold");
        hand(0, 0, 0, 0, 0, 0, "reset_state");

        cycle(0, 0, 1, 0, "enter_set_hour");
        repeat (3) cycle(0, 0, 0, 1, "inc_hour");
        cycle(0, 0, 1, 0, "to_set_min");
        repeat (59) cycle(0, 0, 0, 1, "inc_min");
        cycle(0, 0, 1, 0, "to_run");
        repeat (59) cycle(0, 1, 0, 0, "tick");
        hand(59, 59, 3, 0, 0, 0, "sec_59");
        cycle(0, 1, 0, 0, "sec_carry_tick");
        hand(0, 0, 4, 0, 0, 0, "carry_to_hour");

        cycle(0, 0, 1, 0, "enter_set_hour");
        repeat (19) cycle(0, 0, 0, 1, "inc_hour");
        cycle(0, 0, 1, 0, "to_set_min");
        repeat (59) cycle(0, 0, 0, 1, "inc_min");
        cycle(0, 0, 1, 0, "to_run");
        hand(0, 59, 11, 1, 0, 0, "set_1159pm");
        repeat (59) cycle(0, 1, 0, 0, "tick");
        hand(59, 59, 11, 1, 0, 0, "pre_midnight");
        cycle(0, 1, 0, 0, "midnight_tick");
        hand(0, 0, 0, 0, 0, 0, "midnight");

        repeat (5) cycle(0, 1, 0, 0, "tick");
        cycle(0, 0, 1, 0, "enter_set_hour");
        hand(5, 0, 0, 0, 1, 1, "set_hour_entry");
        repeat (12) cycle(0, 0, 0, 1, "inc_hour");
        hand(5, 0, 0, 1, 1, 1, "hour_wrap12");
        cycle(0, 0, 1, 0, "to_set_min");
        hand(5, 0, 0, 1, 2, 1, "set_min_entry");
        repeat (61) cycle(0, 0, 0, 1, "inc_min");
        hand(5, 1, 0, 1, 2, 1, "min_wrap61");
        repeat (3) cycle(0, 1, 0, 0, "frozen_tick");
        hand(5, 1, 0, 1, 2, 0, "frozen_sec");
        cycle(0, 0, 1, 0, "to_run");
        hand(0, 1, 0, 1, 0, 0, "exit_clears_sec");

        cycle(0, 0, 1, 0, "enter_set_hour");
        cycle(0, 0, 1, 1, "mode_and_inc");
        hand(0, 1, 0, 1, 2, 1, "mode_beats_inc");
        cycle(0, 0, 1, 0, "to_run");
        repeat (10) cycle(0, 1, 0, 0, "tick");
        hand(10, 1, 0, 1, 0, 0, "sec_10");
        cycle(0, 1, 1, 0, "tick_and_mode");
        hand(11, 1, 0, 1, 1, 1, "tick_mode_together");

        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, "blink_tick");
            hand(11, 1, 0, 1, 1, int'(exp_b[i]), $sformatf("blink_seq_%0d", i));
        end
        cycle(0, 0, 1, 0, "to_set_min");
        cycle(0, 0, 1, 0, "to_run");
        hand(0, 1, 0, 1, 0, 0, "blink_off_run");

        cycle(0, 0, 1, 0, "enter_set_hour");
        cycle(0, 0, 1, 0, "to_set_min");
        repeat (36) cycle(0, 0, 0, 1, "inc_min");
        hand(0, 37, 0, 1, 2, 1, "min_37");
        cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), "reset_mid_set");
        hand(0, 0, 0, 0, 0, 0, "after_reset");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
